multiport_memory: RTL and testbench

MULTIPORT_MEMORY -- requirements
Module: multiport_memory

---
 rtl/mem_pkg.sv | 18 +
 rtl/mem_rd_pipe.sv | 63 ++++++
 rtl/multiport_memory.sv | 188 ++++++++++++++++++
 tb/tb_multiport_memory.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// -----------------------------------------------------------------------------
// mem_pkg
// Shared types and constants for the multiport memory slice.
//   mem_state_e : controller state (MEM_CLEAR zero-fills, MEM_RUN serves traffic)
//   MAX_RD_LAT  : deepest read delay line a read port may be configured for
//   ADDR_W      : width of every byte address port
// -----------------------------------------------------------------------------
package mem_pkg;

  typedef enum logic {
    MEM_CLEAR = 1'b0,
    MEM_RUN   = 1'b1
  } mem_state_e;

  localparam int MAX_RD_LAT = 4;
  localparam int ADDR_W     = 32;

endpackage

// File: rtl/mem_rd_pipe.sv
// -----------------------------------------------------------------------------
// mem_rd_pipe
// Fixed-latency delay line for one read port. A response entered on i_valid
// leaves on o_valid exactly LAT clock edges later; there is no backpressure.
// Data registers only load when a valid response passes through them, so
// o_data holds the last delivered word while o_valid is low. o_err is only
// ever high together with o_valid.
// Ports:
//   clk, reset        clock, synchronous active-low reset (flushes all stages)
//   i_valid/i_err/i_data   response captured at acceptance time
//   o_valid/o_err/o_data   delayed response
// -----------------------------------------------------------------------------
module mem_rd_pipe
  import mem_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int LAT    = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_valid,
  input  logic              i_err,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_valid,
  output logic              o_err,
  output logic [DATA_W-1:0] o_data
);

  // Out-of-range latencies are clamped rather than producing a broken pipe.
  localparam int L = (LAT < 1) ? 1 : ((LAT > MAX_RD_LAT) ? MAX_RD_LAT : LAT);

  logic [L-1:0]      r_valid;
  logic [L-1:0]      r_err;
  logic [DATA_W-1:0] r_data [L];

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_valid <= '0;
      r_err   <= '0;
      for (int k = 0; k < L; k++) begin
        r_data[k] <= '0;
      end
    end else begin
      r_valid[0] <= i_valid;
      r_err[0]   <= i_valid & i_err;
      if (i_valid) begin
        r_data[0] <= i_data;
      end
      for (int k = 1; k < L; k++) begin
        r_valid[k] <= r_valid[k-1];
        r_err[k]   <= r_err[k-1];
        if (r_valid[k-1]) begin
          r_data[k] <= r_data[k-1];
        end
      end
    end
  end

  assign o_valid = r_valid[L-1];
  assign o_err   = r_err[L-1];
  assign o_data  = r_data[L-1];

endmodule

// File: rtl/multiport_memory.sv
// -----------------------------------------------------------------------------
// multiport_memory
// Word-addressed RAM with one byte-enabled write port and NUM_RD read ports.
// After reset release, and on clear_req sampled in RUN, the controller walks
// every word writing zero (one word per cycle) before serving traffic again.
//
// Handshake: a request on a channel is accepted on a rising edge where its
// valid and ready are both high. ready is high exactly in MEM_RUN, never
// depends on valid, and responses cannot be backpressured: a write response
// pulses one cycle after acceptance, a read response RD_LAT cycles after.
//
// Ports:
//   clk, reset              clock, synchronous active-low reset
//   clear_req, busy         zero-fill request; busy high while not in RUN
//   wr_valid/wr_ready       write request handshake
//   wr_addr/wr_data/wr_strb byte address, data, byte enables
//   wr_resp_valid/_err      write-done pulse, set err when the write was rejected
//   rd_valid/rd_ready       per-port read handshake
//   rd_addr                 per-port byte addresses, port i at [i*32 +: 32]
//   rd_resp_valid/_data/_err per-port read response
//   dbg_state               controller state for observation
// -----------------------------------------------------------------------------
module multiport_memory
  import mem_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int DEPTH_LOG2 = 10,
  parameter int NUM_RD     = 2,
  parameter int RD_LAT     = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clear_req,
  output logic                     busy,
  input  logic                     wr_valid,
  output logic                     wr_ready,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic [DATA_W/8-1:0]      wr_strb,
  output logic                     wr_resp_valid,
  output logic                     wr_resp_err,
  input  logic [NUM_RD-1:0]        rd_valid,
  output logic [NUM_RD-1:0]        rd_ready,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD-1:0]        rd_resp_valid,
  output logic [NUM_RD*DATA_W-1:0] rd_resp_data,
  output logic [NUM_RD-1:0]        rd_resp_err,
  output mem_state_e               dbg_state
);

  localparam int STRB_W = DATA_W / 8;
  localparam int OFF_W  = $clog2(STRB_W);
  localparam int DEPTH  = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2-1:0] IDX_ONE = 1;

  // ---------------------------------------------------------------------------
  // Controller: state, clear index and the registered handshake outputs.
  // ---------------------------------------------------------------------------
  mem_state_e            r_state;
  logic [DEPTH_LOG2-1:0] r_clr_idx;
  logic                  r_ready;
  logic                  r_busy;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state   <= MEM_CLEAR;
      r_clr_idx <= '0;
      r_ready   <= 1'b0;
      r_busy    <= 1'b1;
    end else begin
      case (r_state)
        MEM_CLEAR: begin
          // clear_req is deliberately not looked at here: a clear in
          // progress always runs to the last word without restarting.
          if (&r_clr_idx) begin
            r_state   <= MEM_RUN;
            r_clr_idx <= '0;
            r_ready   <= 1'b1;
            r_busy    <= 1'b0;
          end else begin
            r_clr_idx <= r_clr_idx + IDX_ONE;
          end
        end
        MEM_RUN: begin
          if (clear_req) begin
            r_state   <= MEM_CLEAR;
            r_clr_idx <= '0;
            r_ready   <= 1'b0;
            r_busy    <= 1'b1;
          end
        end
        default: begin
          r_state   <= MEM_CLEAR;
          r_clr_idx <= '0;
          r_ready   <= 1'b0;
          r_busy    <= 1'b1;
        end
      endcase
    end
  end

  assign busy      = r_busy;
  assign wr_ready  = r_ready;
  assign rd_ready  = {NUM_RD{r_ready}};
  assign dbg_state = r_state;

  // ---------------------------------------------------------------------------
  // Write channel decode. An address is bad when it is not word aligned or
  // any word-index bit above the array size is set.
  // ---------------------------------------------------------------------------
  logic                  w_wr_acc;
  logic                  w_wr_bad;
  logic [DEPTH_LOG2-1:0] w_wr_idx;

  assign w_wr_acc = wr_valid & r_ready;
  assign w_wr_bad = (|wr_addr[OFF_W-1:0]) | (|wr_addr[ADDR_W-1:OFF_W+DEPTH_LOG2]);
  assign w_wr_idx = wr_addr[OFF_W +: DEPTH_LOG2];

  // ---------------------------------------------------------------------------
  // Storage. Clearing and normal writes are mutually exclusive because the
  // write port is only ready in RUN. Reads sample the array combinationally
  // at acceptance, so a same-cycle write to the same word is not yet visible.
  // ---------------------------------------------------------------------------
  logic [DATA_W-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (r_state == MEM_CLEAR) begin
      r_mem[r_clr_idx] <= '0;
    end else if (w_wr_acc && !w_wr_bad) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (wr_strb[b]) begin
          r_mem[w_wr_idx][b*8 +: 8] <= wr_data[b*8 +: 8];
        end
      end
    end
  end

  // Write response: one pulse per accepted write, flushed by reset.
  logic r_wr_resp_valid;
  logic r_wr_resp_err;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_wr_resp_valid <= 1'b0;
      r_wr_resp_err   <= 1'b0;
    end else begin
      r_wr_resp_valid <= w_wr_acc;
      r_wr_resp_err   <= w_wr_acc & w_wr_bad;
    end
  end

  assign wr_resp_valid = r_wr_resp_valid;
  assign wr_resp_err   = r_wr_resp_err;

  // ---------------------------------------------------------------------------
  // Read ports. Each port decodes its own address, samples the array at
  // acceptance and hands the result to its delay line. Reads already in a
  // delay line keep flowing when a clear starts; only reset flushes them.
  // ---------------------------------------------------------------------------
  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    logic [ADDR_W-1:0]     w_addr;
    logic                  w_acc;
    logic                  w_bad;
    logic [DEPTH_LOG2-1:0] w_idx;
    logic [DATA_W-1:0]     w_data;

    assign w_addr = rd_addr[i*ADDR_W +: ADDR_W];
    assign w_acc  = rd_valid[i] & r_ready;
    assign w_bad  = (|w_addr[OFF_W-1:0]) | (|w_addr[ADDR_W-1:OFF_W+DEPTH_LOG2]);
    assign w_idx  = w_addr[OFF_W +: DEPTH_LOG2];
    assign w_data = w_bad ? '0 : r_mem[w_idx];

    mem_rd_pipe #(
      .DATA_W (DATA_W),
      .LAT    (RD_LAT)
    ) u_rd_pipe (
      .clk     (clk),
      .reset   (reset),
      .i_valid (w_acc),
      .i_err   (w_bad),
      .i_data  (w_data),
      .o_valid (rd_resp_valid[i]),
      .o_err   (rd_resp_err[i]),
      .o_data  (rd_resp_data[i*DATA_W +: DATA_W])
    );
  end

endmodule

// File: tb/tb_multiport_memory.sv
// -----------------------------------------------------------------------------
// tb_multiport_memory
// Two instances share the request buses and differ in geometry:
//   u_s : DEPTH_LOG2=4,  RD_LAT=1  (short clear, small address range)
//   u_b : DEPTH_LOG2=10, RD_LAT=3  (pipelined reads, large address range)
// Only one instance sees a valid at a time. Expected responses, including the
// cycle they must appear in, are pushed when a request is issued; a monitor on
// the falling edge pops and compares whenever a response valid is high.
// -----------------------------------------------------------------------------
module tb_multiport_memory;
  import mem_pkg::*;

  // clock / reset
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // shared request buses
  logic        clear_req = 1'b0;
  logic [31:0] wr_addr = '0;
  logic [31:0] wr_data = '0;
  logic [3:0]  wr_strb = '0;
  logic [63:0] rd_addr = '0;
  logic        s_wr_valid = 1'b0;
  logic        b_wr_valid = 1'b0;
  logic [1:0]  s_rd_valid = '0;
  logic [1:0]  b_rd_valid = '0;

  // outputs
  logic        s_busy, s_wr_ready, s_wr_resp_valid, s_wr_resp_err;
  logic [1:0]  s_rd_ready, s_rd_resp_valid, s_rd_resp_err;
  logic [63:0] s_rd_resp_data;
  mem_state_e  s_state;
  logic        b_busy, b_wr_ready, b_wr_resp_valid, b_wr_resp_err;
  logic [1:0]  b_rd_ready, b_rd_resp_valid, b_rd_resp_err;
  logic [63:0] b_rd_resp_data;
  mem_state_e  b_state;

  multiport_memory #(.DATA_W(32), .DEPTH_LOG2(4), .NUM_RD(2), .RD_LAT(1)) u_s (
    .clk(clk), .reset(reset), .clear_req(clear_req), .busy(s_busy),
    .wr_valid(s_wr_valid), .wr_ready(s_wr_ready), .wr_addr(wr_addr),
    .wr_data(wr_data), .wr_strb(wr_strb),
    .wr_resp_valid(s_wr_resp_valid), .wr_resp_err(s_wr_resp_err),
    .rd_valid(s_rd_valid), .rd_ready(s_rd_ready), .rd_addr(rd_addr),
    .rd_resp_valid(s_rd_resp_valid), .rd_resp_data(s_rd_resp_data),
    .rd_resp_err(s_rd_resp_err), .dbg_state(s_state)
  );

  multiport_memory #(.DATA_W(32), .DEPTH_LOG2(10), .NUM_RD(2), .RD_LAT(3)) u_b (
    .clk(clk), .reset(reset), .clear_req(clear_req), .busy(b_busy),
    .wr_valid(b_wr_valid), .wr_ready(b_wr_ready), .wr_addr(wr_addr),
    .wr_data(wr_data), .wr_strb(wr_strb),
    .wr_resp_valid(b_wr_resp_valid), .wr_resp_err(b_wr_resp_err),
    .rd_valid(b_rd_valid), .rd_ready(b_rd_ready), .rd_addr(rd_addr),
    .rd_resp_valid(b_rd_resp_valid), .rd_resp_data(b_rd_resp_data),
    .rd_resp_err(b_rd_resp_err), .dbg_state(b_state)
  );

  // scoreboard: entry = {due_cycle[15:0], err, data[31:0]}
  // read queues 0,1 -> u_s ports, 2,3 -> u_b ports; write queues 0 -> u_s, 1 -> u_b
  logic [48:0] rq [4][$];
  logic [48:0] wq [2][$];
  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // monitor
  always @(negedge clk) begin
    logic [3:0]   v;
    logic [3:0]   e;
    logic [127:0] d;
    logic [1:0]   wv;
    logic [1:0]   we;
    logic [48:0]  h;
    v  = {b_rd_resp_valid, s_rd_resp_valid};
    e  = {b_rd_resp_err, s_rd_resp_err};
    d  = {b_rd_resp_data, s_rd_resp_data};
    wv = {b_wr_resp_valid, s_wr_resp_valid};
    we = {b_wr_resp_err, s_wr_resp_err};
    for (int k = 0; k < 4; k++) begin
      if (v[k] === 1'b1) begin
        if (rq[k].size() == 0) begin
          check($sformatf("rd%0d unexpected response", k), 64'(v[k]), 64'd0);
        end else begin
          h = rq[k].pop_front();
          check($sformatf("rd%0d err/data", k), 64'({e[k], d[k*32 +: 32]}), 64'(h[32:0]));
          check($sformatf("rd%0d response cycle", k), 64'(cyc), 64'(h[48:33]));
        end
      end else if (rq[k].size() != 0) begin
        if (rq[k][0][48:33] <= 16'(cyc)) begin
          h = rq[k].pop_front();
          check($sformatf("rd%0d missing response", k), 64'(v[k]), 64'd1);
        end
      end
    end
    for (int k = 0; k < 2; k++) begin
      if (wv[k] === 1'b1) begin
        if (wq[k].size() == 0) begin
          check($sformatf("wr%0d unexpected response", k), 64'(wv[k]), 64'd0);
        end else begin
          h = wq[k].pop_front();
          check($sformatf("wr%0d err", k), 64'(we[k]), 64'(h[32]));
          check($sformatf("wr%0d response cycle", k), 64'(cyc), 64'(h[48:33]));
        end
      end else if (wq[k].size() != 0) begin
        if (wq[k][0][48:33] <= 16'(cyc)) begin
          h = wq[k].pop_front();
          check($sformatf("wr%0d missing response", k), 64'(wv[k]), 64'd1);
        end
      end
    end
  end

  // driver tasks (called at a falling edge)
  task automatic step();
    @(negedge clk);
    s_wr_valid = 1'b0;
    b_wr_valid = 1'b0;
    s_rd_valid = '0;
    b_rd_valid = '0;
    clear_req  = 1'b0;
  endtask

  task automatic issue_rd(input int inst, input int port, input logic [31:0] addr,
                          input logic [31:0] exp_d, input logic exp_e, input bit track);
    logic rdy;
    rdy = (inst == 0) ? s_rd_ready[port] : b_rd_ready[port];
    check($sformatf("rd_ready inst%0d port%0d", inst, port), 64'(rdy), 64'd1);
    rd_addr[port*32 +: 32] = addr;
    if (inst == 0) begin
      s_rd_valid[port] = 1'b1;
      if (track) rq[port].push_back({16'(cyc + 1), exp_e, exp_d});
    end else begin
      b_rd_valid[port] = 1'b1;
      if (track) rq[2+port].push_back({16'(cyc + 3), exp_e, exp_d});
    end
  endtask

  task automatic issue_wr(input int inst, input logic [31:0] addr, input logic [31:0] data,
                          input logic [3:0] strb, input logic exp_e);
    logic rdy;
    rdy = (inst == 0) ? s_wr_ready : b_wr_ready;
    check($sformatf("wr_ready inst%0d", inst), 64'(rdy), 64'd1);
    wr_addr = addr;
    wr_data = data;
    wr_strb = strb;
    if (inst == 0) s_wr_valid = 1'b1;
    else           b_wr_valid = 1'b1;
    wq[inst].push_back({16'(cyc + 1), exp_e, 32'd0});
  endtask

  task automatic wait_idle(input int inst, input int limit, output int n);
    n = 0;
    while ((((inst == 0) ? s_busy : b_busy) !== 1'b0) && n < limit) begin
      @(negedge clk);
      n++;
    end
    if (n >= limit) check($sformatf("inst%0d leave CLEAR timeout", inst), 64'(n), 64'(limit - 1));
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    // reset state
    repeat (3) @(negedge clk);
    check("rst s_busy", 64'(s_busy), 64'd1);
    check("rst s_wr_ready", 64'(s_wr_ready), 64'd0);
    check("rst s_rd_ready", 64'(s_rd_ready), 64'd0);
    check("rst s_rd_resp_valid", 64'(s_rd_resp_valid), 64'd0);
    check("rst s_rd_resp_err", 64'(s_rd_resp_err), 64'd0);
    check("rst s_rd_resp_data", s_rd_resp_data, 64'd0);
    check("rst s_wr_resp", 64'({s_wr_resp_valid, s_wr_resp_err}), 64'd0);
    check("rst b_busy", 64'(b_busy), 64'd1);
    check("rst b_rd_ready", 64'(b_rd_ready), 64'd0);
    check("rst b_rd_resp_data", b_rd_resp_data, 64'd0);
    check("rst s_state", 64'(s_state), 64'(MEM_CLEAR));
    reset = 1'b1;

    // small instance: 16-cycle clear, then everything reads zero
    wait_idle(0, 100, n);
    check("s clear length", 64'(n), 64'd16);
    check("s state run", 64'(s_state), 64'(MEM_RUN));
    for (int j = 0; j < 8; j++) begin
      issue_rd(0, 0, 32'(j * 8), 32'd0, 1'b0, 1'b1);
      issue_rd(0, 1, 32'(j * 8 + 4), 32'd0, 1'b0, 1'b1);
      step();
    end

    // small instance: clear_req wipes memory; a second request mid-clear is ignored
    issue_wr(0, 32'h4, 32'hA5A5_A5A5, 4'hF, 1'b0);
    step();
    issue_rd(0, 0, 32'h4, 32'hA5A5_A5A5, 1'b0, 1'b1);
    clear_req = 1'b1;
    step();
    n = 0;
    while (s_busy === 1'b1 && n < 100) begin
      clear_req = (n == 4);
      @(negedge clk);
      n++;
    end
    clear_req = 1'b0;
    check("s clear_req clear length", 64'(n), 64'd16);
    issue_rd(0, 0, 32'h4, 32'd0, 1'b0, 1'b1);
    issue_rd(0, 1, 32'h40, 32'd0, 1'b1, 1'b1);
    step();

    // big instance
    wait_idle(1, 1200, n);
    issue_wr(1, 32'h40, 32'hDEAD_BEEF, 4'hF, 1'b0);
    step();
    issue_wr(1, 32'h40, 32'h0000_1100, 4'h2, 1'b0);
    step();
    issue_rd(1, 0, 32'h40, 32'hDEAD_11EF, 1'b0, 1'b1);
    step();
    issue_wr(1, 32'h8, 32'h1234_5678, 4'hF, 1'b0);
    issue_rd(1, 0, 32'h8, 32'd0, 1'b0, 1'b1);
    step();
    issue_rd(1, 1, 32'h8, 32'h1234_5678, 1'b0, 1'b1);
    step();
    issue_rd(1, 0, 32'h6, 32'd0, 1'b1, 1'b1);
    issue_rd(1, 1, 32'h1_0000, 32'd0, 1'b1, 1'b1);
    issue_wr(1, 32'h2, 32'hFFFF_FFFF, 4'hF, 1'b1);
    step();
    issue_rd(1, 0, 32'h0, 32'd0, 1'b0, 1'b1);
    issue_wr(1, 32'h8, 32'hFFFF_FFFF, 4'h0, 1'b0);
    step();
    issue_rd(1, 1, 32'h8, 32'h1234_5678, 1'b0, 1'b1);
    issue_wr(1, 32'hFFC, 32'hCAFE_F00D, 4'hF, 1'b0);
    step();
    issue_rd(1, 0, 32'hFFC, 32'hCAFE_F00D, 1'b0, 1'b1);
    issue_rd(1, 1, 32'h1000, 32'd0, 1'b1, 1'b1);
    issue_wr(1, 32'h4, 32'h0BAD_CAFE, 4'hF, 1'b0);
    step();
    for (int j = 0; j < 8; j++) begin
      issue_rd(1, 0, 32'h4, 32'h0BAD_CAFE, 1'b0, 1'b1);
      issue_rd(1, 1, 32'h4, 32'h0BAD_CAFE, 1'b0, 1'b1);
      step();
    end
    repeat (6) @(negedge clk);
    check("b rd valid idle", 64'(b_rd_resp_valid), 64'd0);
    check("b rd data held", b_rd_resp_data, 64'h0BAD_CAFE_0BAD_CAFE);

    // one-cycle reset with two reads in flight
    issue_rd(1, 0, 32'h40, 32'd0, 1'b0, 1'b0);
    issue_rd(1, 1, 32'h4, 32'd0, 1'b0, 1'b0);
    step();
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    check("b busy after reset", 64'(b_busy), 64'd1);
    for (int j = 0; j < 8; j++) begin
      check("b rd valid after reset", 64'(b_rd_resp_valid), 64'd0);
      @(negedge clk);
    end

    // read in flight completes across a clear_req
    wait_idle(1, 1200, n);
    issue_wr(1, 32'h40, 32'h1122_3344, 4'hF, 1'b0);
    step();
    issue_rd(1, 0, 32'h40, 32'h1122_3344, 1'b0, 1'b1);
    clear_req = 1'b1;
    step();
    check("b busy after clear_req", 64'(b_busy), 64'd1);
    wait_idle(1, 1200, n);
    check("b clear length", 64'(n), 64'd1024);
    issue_rd(1, 0, 32'h40, 32'd0, 1'b0, 1'b1);
    step();
    repeat (6) @(negedge clk);

    for (int k = 0; k < 4; k++) check($sformatf("rd%0d queue drained", k), 64'(rq[k].size()), 64'd0);
    for (int k = 0; k < 2; k++) check($sformatf("wr%0d queue drained", k), 64'(wq[k].size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
